axi_lite_to_obi_rr: RTL
=======================

# axi_lite_to_obi_rr

AXI4-Lite subordinate to single OBI manager bridge with configurable outstanding depth, read/write round-robin (or read-priority) arbitration and credit-based response buffering. It is the lightweight successor of the full AXI-to-OBI bridge and sits in front of register files and peripheral OBI crossbars. It has no ID or bank handling. It guarantees that OBI responses, which cannot be back-pressured, are never dropped when R or B stall.

## Interface
- AddrWidth, 32, AXI and OBI address width
- DataWidth, 32, data width (multiple of 8); strobe width DataWidth/8
- MaxTrans, 4, max transactions accepted but not yet returned on R/B (≥1); sizes both internal FIFOs
- ReadPrio, 0, 0 = round-robin between read and write, 1 = reads always win conflicts
- One clock; reset is synchronous and active-high.
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- aw_addr_i / aw_valid_i / aw_ready_o  in/in/out  AddrWidth/1/1  write address channel
- w_data_i / w_strb_i / w_valid_i / w_ready_o  in/in/in/out  DataWidth/DataWidth/8/1/1  write data channel
- b_resp_o / b_valid_o / b_ready_i  out/out/in  2/1/1  write response
- ar_addr_i / ar_valid_i / ar_ready_o  in/in/out  AddrWidth/1/1  read address
- r_data_o / r_resp_o / r_valid_o / r_ready_i  out/out/out/in  DataWidth/2/1/1  read response
- obi_req_o / obi_gnt_i  out/in  1/1  OBI A-phase handshake
- obi_addr_o / obi_we_o / obi_be_o / obi_wdata_o  out  AddrWidth/1/DataWidth/8/DataWidth  A-phase payload
- obi_rvalid_i / obi_rdata_i / obi_err_i  in  1/DataWidth/1  OBI R-phase
- busy_o  out  1  high while any transaction is held, in flight or buffered

## Operation
- Candidates: write = aw_valid_i && w_valid_i (AW and W accepted together only); read = ar_valid_i.
- Credit counter cnt (0..MaxTrans): +1 on AXI accept, −1 on R or B handshake; simultaneous +1/−1 leaves it unchanged. Accept allowed only if cnt < MaxTrans.
- Slot: one A-phase holding register, states IDLE / REQ. Accept allowed if credit is available and (state IDLE, or state REQ with obi_gnt_i this cycle).
- Arbitration on conflict: ReadPrio=1 means read wins; otherwise the opposite of the last accepted kind wins. last_kind resets to write, so the first conflict grants read. Winner's ready(s) are high; loser's are low.
- aw_ready_o and w_ready_o are always equal; they may depend on the valids.
- On accept: capture addr, we, be (strb; all ones for reads), wdata (0 for reads); state becomes REQ.
- REQ: obi_req_o=1 with payload stable until obi_gnt_i. On gnt, push we into tag FIFO (depth MaxTrans). Return to IDLE unless a new accept happens in the same cycle.
- On obi_rvalid_i: pop tag and push {we, rdata, err} into response FIFO (depth MaxTrans). The credit scheme guarantees this never overflows.
- Response FIFO head: we=0 drives r_valid_o with r_data_o and r_resp_o; we=1 drives b_valid_o with b_resp_o. The other valid is low. Strict in-order retirement across R and B.
- resp = 2'b10 (SLVERR) if err, else 2'b00 (OKAY). b and r data are 0 when not valid.
- obi_rvalid_i with tag FIFO empty is a protocol violation: ignored, with a simulation assertion.
- busy_o = (state==REQ) || cnt!=0.

## Timing
- Reset: all outputs 0; cnt 0; FIFOs empty; state IDLE; last_kind write.
- Reset mid-operation discards held, in-flight and buffered transactions. OBI responses arriving after reset are ignored.
- AXI accept in cycle N gives obi_req_o=1 in N+1. Best case gnt in N+1 gives next obi_req_o in N+2, i.e. one transaction per cycle sustained.
- obi_rvalid_i in cycle M gives r_valid_o/b_valid_o in M+1 (registered FIFO, no bypass).
- Response FIFO full and empty in the same cycle are handled: push and pop in the same cycle are both performed.
- cnt==MaxTrans: all ready outputs are low until an R/B handshake. They rise in the cycle after that handshake.

## Test plan
- Single read: ar_addr=0x40, gnt same cycle, rvalid 2 cycles later with rdata=0xDEADBEEF, err=0 -> r_data_o=0xDEADBEEF, r_resp_o=0, one cycle after rvalid; busy_o returns to 0 after the R handshake.
- Write with error: aw=0x80, w=0x1234 strb=0x3 -> obi_we_o=1, obi_be_o=0x3, obi_wdata_o=0x1234; obi_err_i=1 -> b_resp_o=2'b10.
- Conflict round-robin (ReadPrio=0): read and write both valid continuously -> OBI order read, write, read, write. With ReadPrio=1 -> all reads go first.
- Credit stall (MaxTrans=2): r_ready_i=0, three reads offered -> only two accepted, ar_ready_o low. After one R handshake the third is accepted the next cycle, and the response FIFO never overflows.
- Gnt back-pressure: obi_gnt_i low for 5 cycles -> addr/we/be/wdata stable and obi_req_o held high throughout.
- Reset mid-flight: assert rst_i with 2 outstanding -> all outputs 0 next cycle, late obi_rvalid_i ignored, and a fresh read afterwards completes normally.

Source files
------------

// File: rtl/axi_lite_to_obi_rr.sv
// axi_lite_to_obi_rr
// AXI4-Lite subordinate to single OBI manager bridge. It holds one A-phase
// request at a time and arbitrates read against write, either round-robin or
// with reads always winning. A credit counter bounds the number of accepted but
// unretired transactions to MaxTrans, so OBI responses, which cannot be stalled,
// always fit the response FIFO even while R or B is back-pressured.
//
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   aw_*, w_*, b_*                  AXI4-Lite write address / data / response
//   ar_*, r_*                       AXI4-Lite read address / data
//   obi_req_o, obi_gnt_i            OBI A-phase handshake
//   obi_addr/we/be/wdata_o          OBI A-phase payload
//   obi_rvalid/rdata/err_i          OBI R-phase
//   busy_o                          any transaction held, in flight or buffered
module axi_lite_to_obi_rr #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MaxTrans  = 4,
    parameter bit          ReadPrio  = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [AddrWidth-1:0]   aw_addr_i,
    input  logic                   aw_valid_i,
    output logic                   aw_ready_o,
    input  logic [DataWidth-1:0]   w_data_i,
    input  logic [DataWidth/8-1:0] w_strb_i,
    input  logic                   w_valid_i,
    output logic                   w_ready_o,
    output logic [1:0]             b_resp_o,
    output logic                   b_valid_o,
    input  logic                   b_ready_i,
    input  logic [AddrWidth-1:0]   ar_addr_i,
    input  logic                   ar_valid_i,
    output logic                   ar_ready_o,
    output logic [DataWidth-1:0]   r_data_o,
    output logic [1:0]             r_resp_o,
    output logic                   r_valid_o,
    input  logic                   r_ready_i,
    output logic                   obi_req_o,
    input  logic                   obi_gnt_i,
    output logic [AddrWidth-1:0]   obi_addr_o,
    output logic                   obi_we_o,
    output logic [DataWidth/8-1:0] obi_be_o,
    output logic [DataWidth-1:0]   obi_wdata_o,
    input  logic                   obi_rvalid_i,
    input  logic [DataWidth-1:0]   obi_rdata_i,
    input  logic                   obi_err_i,
    output logic                   busy_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned PtrW      = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam int unsigned CntW      = $clog2(MaxTrans + 1);
    localparam int unsigned RespW     = DataWidth + 2;
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxTrans);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxTrans - 1);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CntW-1:0]       r_cnt;
    logic                  r_last_wr;
    logic                  r_armed;

    logic [AddrWidth-1:0]  r_addr;
    logic                  r_we;
    logic [StrbWidth-1:0]  r_be;
    logic [DataWidth-1:0]  r_wdata;

    logic                  r_tag_mem [MaxTrans];
    logic [PtrW-1:0]       r_tag_wp, r_tag_rp;
    logic [CntW-1:0]       r_tag_cnt;

    logic [RespW-1:0]      r_rsp_mem [MaxTrans];
    logic [PtrW-1:0]       r_rsp_wp, r_rsp_rp;
    logic [CntW-1:0]       r_rsp_cnt;

    logic w_can_acc, w_wr_cand, w_rd_cand, w_rd_wins;
    logic w_acc_rd, w_acc_wr, w_acc, w_gnt_hs;
    logic w_tag_empty, w_tag_pop, w_rsp_vld, w_r_vld, w_b_vld, w_retire;
    logic [RespW-1:0] w_rsp_head;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // Accept needs a credit and a free slot; the slot also frees up in the
    // same cycle the held request is granted, which sustains one per cycle.
    assign w_can_acc = !rst_i && (r_cnt < MaxCnt) && ((r_state == S_IDLE) || obi_gnt_i);
    assign w_wr_cand = aw_valid_i && w_valid_i;
    assign w_rd_cand = ar_valid_i;
    // On conflict the read wins if reads have priority or the last accept was a write.
    assign w_rd_wins = ReadPrio || r_last_wr;
    assign w_acc_rd  = w_can_acc && w_rd_cand && (!w_wr_cand || w_rd_wins);
    assign w_acc_wr  = w_can_acc && w_wr_cand && (!w_rd_cand || !w_rd_wins);
    assign w_acc     = w_acc_rd || w_acc_wr;
    assign w_gnt_hs  = (r_state == S_REQ) && obi_gnt_i;

    assign w_tag_empty = (r_tag_cnt == '0);
    assign w_tag_pop   = obi_rvalid_i && !w_tag_empty;
    assign w_rsp_vld   = (r_rsp_cnt != '0);
    assign w_rsp_head  = r_rsp_mem[r_rsp_rp];
    assign w_r_vld     = w_rsp_vld && !w_rsp_head[RespW-1];
    assign w_b_vld     = w_rsp_vld &&  w_rsp_head[RespW-1];
    assign w_retire    = (w_r_vld && r_ready_i) || (w_b_vld && b_ready_i);

    // Slot state register and control counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_last_wr <= 1'b1;
            r_armed   <= 1'b0;
            r_tag_wp  <= '0;
            r_tag_rp  <= '0;
            r_tag_cnt <= '0;
            r_rsp_wp  <= '0;
            r_rsp_rp  <= '0;
            r_rsp_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc) r_last_wr <= w_acc_wr;
            if (w_gnt_hs) r_armed <= 1'b1;

            case ({w_acc, w_retire})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase

            if (w_gnt_hs)  r_tag_wp <= ptr_inc(r_tag_wp);
            if (w_tag_pop) r_tag_rp <= ptr_inc(r_tag_rp);
            case ({w_gnt_hs, w_tag_pop})
                2'b10:   r_tag_cnt <= r_tag_cnt + 1'b1;
                2'b01:   r_tag_cnt <= r_tag_cnt - 1'b1;
                default: r_tag_cnt <= r_tag_cnt;
            endcase

            if (w_tag_pop) r_rsp_wp <= ptr_inc(r_rsp_wp);
            if (w_retire)  r_rsp_rp <= ptr_inc(r_rsp_rp);
            case ({w_tag_pop, w_retire})
                2'b10:   r_rsp_cnt <= r_rsp_cnt + 1'b1;
                2'b01:   r_rsp_cnt <= r_rsp_cnt - 1'b1;
                default: r_rsp_cnt <= r_rsp_cnt;
            endcase
        end
    end

    // Payload and FIFO storage; validity is tracked by the control state above
    always_ff @(posedge clk_i) begin
        if (w_acc) begin
            r_addr  <= w_acc_rd ? ar_addr_i : aw_addr_i;
            r_we    <= w_acc_wr;
            r_be    <= w_acc_wr ? w_strb_i : '1;
            r_wdata <= w_acc_wr ? w_data_i : '0;
        end
        if (w_gnt_hs)  r_tag_mem[r_tag_wp] <= r_we;
        if (w_tag_pop) r_rsp_mem[r_rsp_wp] <= {r_tag_mem[r_tag_rp], obi_rdata_i, obi_err_i};
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_acc)         w_state_nxt = S_REQ;
        else if (w_gnt_hs) w_state_nxt = S_IDLE;
    end

    // Payload and response data are masked so every output is zero when idle.
    always_comb begin
        obi_req_o   = (r_state == S_REQ);
        obi_addr_o  = obi_req_o ? r_addr  : '0;
        obi_we_o    = obi_req_o && r_we;
        obi_be_o    = obi_req_o ? r_be    : '0;
        obi_wdata_o = obi_req_o ? r_wdata : '0;
        ar_ready_o  = w_acc_rd;
        aw_ready_o  = w_acc_wr;
        w_ready_o   = w_acc_wr;
        r_valid_o   = w_r_vld;
        b_valid_o   = w_b_vld;
        r_data_o    = w_r_vld ? w_rsp_head[DataWidth:1] : '0;
        r_resp_o    = (w_r_vld && w_rsp_head[0]) ? 2'b10 : 2'b00;
        b_resp_o    = (w_b_vld && w_rsp_head[0]) ? 2'b10 : 2'b00;
        busy_o      = (r_state == S_REQ) || (r_cnt != '0);
    end

    // Until the first grant after reset, stray responses may belong to
    // requests issued before reset; they are dropped without complaint.
    always_ff @(posedge clk_i) begin
        if (!rst_i && r_armed && obi_rvalid_i) begin
            assert (!w_tag_empty)
                else $error("obi_rvalid_i with no outstanding OBI request");
        end
    end

endmodule
